// File: rtl/spi_flash_pkg.sv
// ---------------------------------------------------------------------------
// spi_flash_pkg
// Shared definitions for the W25Q16 command sequencers.
//   - Flash opcodes sent through the single-byte SPI write engine.
//   - One-hot state encoding of the chip-erase sequencer FSM.
// ---------------------------------------------------------------------------
package spi_flash_pkg;

  localparam logic [7:0] CMD_WREN = 8'h06;  // Write Enable
  localparam logic [7:0] CMD_CE   = 8'hC7;  // Chip Erase
  localparam logic [7:0] CMD_RDSR = 8'h05;  // Read Status Register (reserved)

  typedef enum logic [8:0] {
    IDLE     = 9'b0_0000_0001,
    WREN_ST  = 9'b0_0000_0010,
    WREN_WT  = 9'b0_0000_0100,
    GAP      = 9'b0_0000_1000,
    CE_ST    = 9'b0_0001_0000,
    CE_WT    = 9'b0_0010_0000,
    ERASE_WT = 9'b0_0100_0000,
    FIN      = 9'b0_1000_0000,
    ERR      = 9'b1_0000_0000
  } seq_state_e;

  // Opcodes that modify the array must be preceded by a Write Enable frame.
  function automatic logic cmd_needs_wren(input logic [7:0] cmd);
    return (cmd != CMD_RDSR) && (cmd != CMD_WREN);
  endfunction

endpackage

// File: rtl/spi_erase_seq_if.sv
// ---------------------------------------------------------------------------
// spi_erase_seq_if
// Bundles the requester handshake and the byte-engine handshake of the
// chip-erase sequencer.
//   erase_req  : requester -> sequencer, one-cycle request pulse
//   busy       : sequencer -> requester, sequence in progress
//   erase_done : sequencer -> requester, one-cycle completion pulse
//   erase_err  : sequencer -> requester, one-cycle engine-timeout pulse
//   spi_start  : sequencer -> engine, one-cycle byte start pulse
//   spi_wrdata : sequencer -> engine, byte to shift out
//   spi_done   : engine -> sequencer, byte done level (idles high)
// Modport slave is the sequencer side; master is the requester/engine side.
// ---------------------------------------------------------------------------
interface spi_erase_seq_if;

  logic       erase_req;
  logic       busy;
  logic       erase_done;
  logic       erase_err;
  logic       spi_start;
  logic [7:0] spi_wrdata;
  logic       spi_done;

  modport slave (
    input  erase_req, spi_done,
    output busy, erase_done, erase_err, spi_start, spi_wrdata
  );

  modport master (
    output erase_req, spi_done,
    input  busy, erase_done, erase_err, spi_start, spi_wrdata
  );

endinterface

// File: rtl/spi_timer.sv
// ---------------------------------------------------------------------------
// spi_timer
// Loadable down-counter. Loading value N-1 and enabling it every cycle makes
// o_expired true on the N-th enabled cycle after the load. The count parks at
// zero, so it never wraps.
//   i_clk      : clock
//   i_rst      : synchronous active-high reset, count -> 0
//   i_load     : load i_load_val (has priority over counting)
//   i_load_val : value to load
//   i_en       : decrement while non-zero
//   o_expired  : count is zero
// ---------------------------------------------------------------------------
module spi_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expired
);

  logic [WIDTH-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/spi_erase_seq.sv
// ---------------------------------------------------------------------------
// spi_erase_seq
// W25Q16 chip-erase sequencer: on a request it sends WREN (06h) through the
// byte engine, idles GAP_CYC cycles with CS high, sends CE (C7h), then waits
// ERASE_CYC cycles before pulsing erase_done. If the engine does not answer
// within TMO_CYC cycles of a start, erase_err pulses instead.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset
//   if_bus : slave side of spi_erase_seq_if (request + engine handshakes)
// All interface outputs come straight from registers.
// ---------------------------------------------------------------------------
module spi_erase_seq
  import spi_flash_pkg::*;
#(
  parameter logic [7:0]  GAP_CYC   = 8'd8,
  parameter logic [31:0] ERASE_CYC = 32'd1_250_000_000,
  parameter logic [15:0] TMO_CYC   = 16'd64
) (
  input  logic           i_clk,
  input  logic           i_rst,
  spi_erase_seq_if.slave if_bus
);

  seq_state_e r_state;
  logic       r_busy;
  logic       r_erase_done;
  logic       r_erase_err;
  logic       r_spi_start;
  logic [7:0] r_spi_wrdata;
  logic       r_spi_done_q;

  logic w_done_acc;
  logic w_in_wt;
  logic w_gap_load, w_gap_exp;
  logic w_erase_load, w_erase_exp;
  logic w_tmo_load, w_tmo_exp;

  // The engine's done idles high, so only a low->high transition seen while
  // waiting on a byte counts. The history register resets high so a level
  // present straight out of reset never looks like an edge.
  assign w_in_wt    = (r_state == WREN_WT) || (r_state == CE_WT);
  assign w_done_acc = w_in_wt && if_bus.spi_done && !r_spi_done_q;

  assign w_gap_load   = (r_state == WREN_WT) && w_done_acc;
  assign w_erase_load = (r_state == CE_WT) && w_done_acc;
  assign w_tmo_load   = (r_state == WREN_ST) || (r_state == CE_ST);

  spi_timer #(.WIDTH(8)) u_gap_tmr (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_gap_load),
    .i_load_val (GAP_CYC - 8'd1),
    .i_en       (r_state == GAP),
    .o_expired  (w_gap_exp)
  );

  spi_timer #(.WIDTH(32)) u_erase_tmr (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_erase_load),
    .i_load_val (ERASE_CYC - 32'd1),
    .i_en       (r_state == ERASE_WT),
    .o_expired  (w_erase_exp)
  );

  spi_timer #(.WIDTH(16)) u_tmo_tmr (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_tmo_load),
    .i_load_val (TMO_CYC - 16'd1),
    .i_en       (w_in_wt),
    .o_expired  (w_tmo_exp)
  );

  // Outputs are registered together with the state transition, so each
  // output is valid during the cycle the FSM spends in the matching state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_erase_done <= 1'b0;
      r_erase_err  <= 1'b0;
      r_spi_start  <= 1'b0;
      r_spi_wrdata <= 8'h00;
      r_spi_done_q <= 1'b1;
    end else begin
      r_spi_done_q <= if_bus.spi_done;
      r_spi_start  <= 1'b0;
      r_erase_done <= 1'b0;
      r_erase_err  <= 1'b0;

      case (r_state)
        IDLE: begin
          if (if_bus.erase_req) begin
            r_state      <= WREN_ST;
            r_busy       <= 1'b1;
            r_spi_start  <= 1'b1;
            r_spi_wrdata <= CMD_WREN;
          end
        end
        WREN_ST: r_state <= WREN_WT;
        WREN_WT: begin
          // Done takes priority over a timeout landing in the same cycle.
          if (w_done_acc) begin
            r_state <= GAP;
          end else if (w_tmo_exp) begin
            r_state     <= ERR;
            r_erase_err <= 1'b1;
          end
        end
        GAP: begin
          if (w_gap_exp) begin
            r_state      <= CE_ST;
            r_spi_start  <= 1'b1;
            r_spi_wrdata <= CMD_CE;
          end
        end
        CE_ST: r_state <= CE_WT;
        CE_WT: begin
          if (w_done_acc) begin
            r_state <= ERASE_WT;
          end else if (w_tmo_exp) begin
            r_state     <= ERR;
            r_erase_err <= 1'b1;
          end
        end
        ERASE_WT: begin
          if (w_erase_exp) begin
            r_state      <= FIN;
            r_erase_done <= 1'b1;
          end
        end
        FIN, ERR: begin
          r_state      <= IDLE;
          r_busy       <= 1'b0;
          r_spi_wrdata <= 8'h00;
        end
        default: begin
          r_state      <= IDLE;
          r_busy       <= 1'b0;
          r_spi_wrdata <= 8'h00;
        end
      endcase
    end
  end

  assign if_bus.busy       = r_busy;
  assign if_bus.erase_done = r_erase_done;
  assign if_bus.erase_err  = r_erase_err;
  assign if_bus.spi_start  = r_spi_start;
  assign if_bus.spi_wrdata = r_spi_wrdata;

endmodule

// File: tb/tb_spi_erase_seq.sv
// ---------------------------------------------------------------------------
// tb_spi_erase_seq
// Directed bench for spi_erase_seq with GAP_CYC=4, ERASE_CYC=100, TMO_CYC=32.
// A behavioural byte engine answers each spi_start with a one-cycle done
// pulse eng_dly cycles later; a negedge monitor logs start/edge/done/err
// cycles, and each scenario compares those against hand-derived numbers:
//   WREN start -> CE start           = dly + GAP + 1   (17 for dly=12)
//   WREN done edge -> CE start       = GAP + 1         (5)
//   CE done edge -> erase_done       = ERASE + 1       (101)
//   CE start -> erase_err (no answer) = TMO + 1        (33: 32 CE_WT cycles,
//                                      error visible the cycle after)
// ---------------------------------------------------------------------------
module tb_spi_erase_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_erase_seq_if intf ();

  spi_erase_seq #(
    .GAP_CYC   (8'd4),
    .ERASE_CYC (32'd100),
    .TMO_CYC   (16'd32)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .if_bus (intf)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // ---------------- engine model ----------------
  int eng_dly        = 12;
  int eng_hold       = 0;    // cycles done stays high after a start
  bit eng_mute_ce    = 1'b0; // never answer the C7h byte
  bit eng_force_high = 1'b0; // park done high (engine held in reset)

  initial begin : engine_model
    int age;
    bit armed;
    age   = -1;
    armed = 1'b0;
    intf.spi_done = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (eng_force_high) begin
        age = -1;
        intf.spi_done = 1'b1;
      end else begin
        if (intf.spi_start) begin
          age   = 0;
          armed = !(eng_mute_ce && (intf.spi_wrdata == 8'hC7));
        end else if (age >= 0) begin
          age++;
        end
        if (age >= 0)
          intf.spi_done = (age < eng_hold) || (armed && (age == eng_dly));
      end
    end
  end

  // ---------------- monitor ----------------
  int         cyc = 0;
  int         st_cyc_q[$];
  logic [7:0] st_byte_q[$];
  int         edge_q[$];
  int         n_done = 0, done_cyc = 0;
  int         n_err = 0, err_cyc = 0;
  logic       mon_prev_done = 1'b1;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (intf.spi_start) begin
      st_cyc_q.push_back(cyc);
      st_byte_q.push_back(intf.spi_wrdata);
    end
    if (intf.spi_done && !mon_prev_done) edge_q.push_back(cyc);
    mon_prev_done = intf.spi_done;
    if (intf.erase_done) begin n_done++; done_cyc = cyc; end
    if (intf.erase_err)  begin n_err++;  err_cyc  = cyc; end
  end

  function automatic int st_at(input int i);
    return (i < st_cyc_q.size()) ? st_cyc_q[i] : -1000;
  endfunction
  function automatic int byte_at(input int i);
    return (i < st_byte_q.size()) ? int'(st_byte_q[i]) : -1;
  endfunction
  function automatic int edge_at(input int i);
    return (i < edge_q.size()) ? edge_q[i] : -1000;
  endfunction

  // ---------------- helpers ----------------
  int b_st, b_edge, b_done, b_err;

  task automatic settle();
    #2;
  endtask

  task automatic snap();
    settle();
    b_st   = st_cyc_q.size();
    b_edge = edge_q.size();
    b_done = n_done;
    b_err  = n_err;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Ends at the negedge of the cycle right after the request edge.
  task automatic pulse_req();
    @(negedge clk);
    intf.erase_req = 1'b1;
    @(negedge clk);
    intf.erase_req = 1'b0;
  endtask

  // Wait for erase_done or erase_err, checking busy stays high meanwhile.
  task automatic wait_end(input string tag, input int budget);
    int n, nb;
    bit hit;
    n = 0; nb = 0; hit = 1'b0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (!intf.busy) nb++;
      if (intf.erase_done || intf.erase_err) begin
        hit = 1'b1;
        break;
      end
    end
    check({tag, "_finished"}, int'(hit), 1);
    check({tag, "_busy_held"}, nb, 0);
  endtask

  // ---------------- scenarios ----------------
  initial begin : main
    rst = 1'b1;
    intf.erase_req = 1'b0;

    // Reset values.
    do_reset();
    @(negedge clk);
    check("rst_busy",   int'(intf.busy), 0);
    check("rst_done",   int'(intf.erase_done), 0);
    check("rst_err",    int'(intf.erase_err), 0);
    check("rst_start",  int'(intf.spi_start), 0);
    check("rst_wrdata", int'(intf.spi_wrdata), 0);

    // Nominal sequence.
    snap();
    pulse_req();
    check("nom_busy_c0",  int'(intf.busy), 1);
    check("nom_start_c0", int'(intf.spi_start), 1);
    check("nom_data_c0",  int'(intf.spi_wrdata), 'h06);
    wait_end("nom", 400);
    check("nom_fin_busy", int'(intf.busy), 1);
    settle();
    check("nom_n_start",   st_cyc_q.size() - b_st, 2);
    check("nom_byte0",     byte_at(b_st), 'h06);
    check("nom_byte1",     byte_at(b_st + 1), 'hC7);
    check("nom_start2start", st_at(b_st + 1) - st_at(b_st), 17);
    check("nom_gap",       st_at(b_st + 1) - edge_at(b_edge), 5);
    check("nom_erase_lat", done_cyc - edge_at(b_edge + 1), 101);
    check("nom_n_done",    n_done - b_done, 1);
    check("nom_n_err",     n_err - b_err, 0);
    @(negedge clk);
    check("nom_busy_fall", int'(intf.busy), 0);
    check("nom_idle_data", int'(intf.spi_wrdata), 0);

    // done held high out of reset: stale level must not be accepted.
    eng_force_high = 1'b1;
    do_reset();
    eng_force_high = 1'b0;
    eng_hold = 6;
    snap();
    pulse_req();
    wait_end("hold", 400);
    settle();
    check("hold_start2start", st_at(b_st + 1) - st_at(b_st), 17);
    check("hold_n_done", n_done - b_done, 1);
    check("hold_n_err",  n_err - b_err, 0);
    eng_hold = 0;

    // Engine never answers CE: timeout.
    eng_mute_ce = 1'b1;
    snap();
    pulse_req();
    wait_end("tmo", 400);
    settle();
    check("tmo_n_err",  n_err - b_err, 1);
    check("tmo_n_done", n_done - b_done, 0);
    check("tmo_err_lat", err_cyc - st_at(b_st + 1), 33);
    @(negedge clk);
    check("tmo_idle_busy", int'(intf.busy), 0);
    eng_mute_ce = 1'b0;
    snap();
    pulse_req();
    check("tmo_restart_start", int'(intf.spi_start), 1);
    check("tmo_restart_data",  int'(intf.spi_wrdata), 'h06);
    wait_end("tmo_restart", 400);
    settle();
    check("tmo_restart_n_done", n_done - b_done, 1);

    // Requests during GAP and ERASE_WT are dropped.
    snap();
    pulse_req();
    repeat (13) @(negedge clk);
    pulse_req();              // lands in GAP
    repeat (30) @(negedge clk);
    pulse_req();              // lands in ERASE_WT
    wait_end("rwb", 400);
    repeat (40) @(negedge clk);
    settle();
    check("rwb_n_start",   st_cyc_q.size() - b_st, 2);
    check("rwb_n_done",    n_done - b_done, 1);
    check("rwb_erase_lat", done_cyc - edge_at(b_edge + 1), 101);

    // Reset during CE_WT.
    snap();
    pulse_req();
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy",   int'(intf.busy), 0);
    check("mrst_start",  int'(intf.spi_start), 0);
    check("mrst_wrdata", int'(intf.spi_wrdata), 0);
    check("mrst_done",   int'(intf.erase_done), 0);
    check("mrst_err",    int'(intf.erase_err), 0);
    repeat (30) @(negedge clk);
    settle();
    check("mrst_quiet_start", st_cyc_q.size() - b_st, 2);
    check("mrst_quiet_done",  n_done - b_done, 0);
    check("mrst_quiet_err",   n_err - b_err, 0);
    snap();
    pulse_req();
    wait_end("mrst_again", 400);
    settle();
    check("mrst_again_byte0", byte_at(b_st), 'h06);
    check("mrst_again_byte1", byte_at(b_st + 1), 'hC7);
    check("mrst_again_done",  n_done - b_done, 1);

    // Done edge on the very cycle the timeout expires: done wins.
    eng_dly = 32;
    snap();
    pulse_req();
    wait_end("coll", 600);
    settle();
    check("coll_n_err",  n_err - b_err, 0);
    check("coll_n_done", n_done - b_done, 1);
    check("coll_start2start", st_at(b_st + 1) - st_at(b_st), 37);
    check("coll_erase_lat", done_cyc - edge_at(b_edge + 1), 101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_erase_seq.md
# spi_erase_seq

Command sequencer for the W25Q16 chip-erase flow. It sits between the user/top-level FSM and the single-byte SPI write engine (CPOL=0, CPHA=0; one CS frame per byte, start/done handshake). On one request it issues Write Enable (06h), waits a CS-high gap, issues Chip Erase (C7h), then times the flash erase interval before reporting completion. An engine timeout raises an error.

## Interface
- `GAP_CYC`, default 8: clk cycles of idle (engine CS high) between the WREN frame end and the CE start; legal range ≥1.
- `ERASE_CYC`, default 32'd1_250_000_000: post-CE wait in clk cycles (25 s at 50 MHz); legal range ≥1.
- `TMO_CYC`, default 16'd64: maximum cycles from `spi_start` to an accepted `spi_done`; legal range ≥2.
- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: reset, synchronous, active-high.
- `erase_req` in 1: one-cycle request pulse. Ignored while `busy`=1.
- `busy` out 1: high from the cycle after an accepted request until the `erase_done`/`erase_err` cycle, inclusive.
- `erase_done` out 1: one-cycle pulse; the erase interval has elapsed.
- `erase_err` out 1: one-cycle pulse; the engine timed out.
- `spi_start` out 1: one-cycle start pulse to the byte engine.
- `spi_wrdata` out 8: byte for the engine. Held stable from `spi_start` until `spi_done` is accepted.
- `spi_done` in 1: done indication from the byte engine.

## Operation
- Reset values: `busy`=0, `erase_done`=0, `erase_err`=0, `spi_start`=0, `spi_wrdata`=8'h00. FSM is in IDLE; all counters are 0. All outputs are registered.
- FSM states: IDLE, WREN_ST, WREN_WT, GAP, CE_ST, CE_WT, ERASE_WT, FIN, ERR.
- IDLE → WREN_ST when `erase_req`=1.
- WREN_ST (1 cycle): `spi_start`=1, `spi_wrdata`=CMD_WREN. Then → WREN_WT.
- WREN_WT: on an accepted done → GAP. On timeout → ERR.
- GAP: count GAP_CYC cycles, then → CE_ST.
- CE_ST (1 cycle): `spi_start`=1, `spi_wrdata`=CMD_CE. Then → CE_WT.
- CE_WT: on an accepted done → ERASE_WT. On timeout → ERR.
- ERASE_WT: count ERASE_CYC cycles, then → FIN.
- FIN: `erase_done`=1 for one cycle → IDLE.
- ERR: `erase_err`=1 for one cycle → IDLE.
- Done acceptance: done is accepted only on a rising edge of `spi_done` (high now, low the previous cycle), and only in a *_WT state. Rationale: the engine's `spi_done` resets high, and any level left over from before `spi_start` must not count. The `spi_done` edge register resets to 1, so a high level out of reset is not an edge.
- Timeout counter: cleared in each *_ST state and incremented each cycle in *_WT. Reaching TMO_CYC with no accepted done is a timeout. If an accepted done and the timeout fall in the same cycle, done wins.
- Counter widths: GAP 8 bits, erase 32 bits, timeout 16 bits. Each counter compares against its parameter minus 1; no wrap-around is reachable.
- `erase_req` while busy is dropped; it is not queued. A request in the FIN or ERR cycle is also dropped. A new request is accepted only in IDLE.
- `rst` mid-sequence returns the FSM to IDLE at the next edge with reset output values. Any erase already in progress in the flash is not tracked; the requester must wait ERASE_CYC before issuing a new request.
- `spi_wrdata` returns to 8'h00 in IDLE.

## Timing
- Request seen at edge 0 → `busy`=1 and `spi_start`=1 (06h) after edge 1.
- Let the engine's done edge arrive D cycles after `spi_start`. The CE `spi_start` then goes high D+GAP_CYC+1 cycles after the WREN `spi_start`.
- `erase_done` rises ERASE_CYC+1 cycles after the CE done edge is accepted. `busy` falls on the cycle after `erase_done`.
- With the engine at cnt_max=8, D is 11–12 cycles. End-to-end time is ≈ 2D + GAP_CYC + ERASE_CYC + 4.

## Structure
- Shared package `spi_flash_pkg`:
  - command constants CMD_WREN=8'h06, CMD_CE=8'hC7, CMD_RDSR=8'h05 (reserved);
  - the FSM state encoding, one-hot, 9 bits.
- One sub-module: `spi_timer`, a load/count/expire down-counter with a width parameter. It is instantiated three times: gap, erase and timeout.
- Estimated size: ≈200 lines of RTL.

## Test plan
Bench parameters: GAP_CYC=4, ERASE_CYC=100, TMO_CYC=32. The engine model raises `spi_done` for 1 cycle, 12 cycles after `spi_start`.
- Nominal: a single `erase_req` → exactly two `spi_start` pulses, carrying 06h then C7h. The gap between the WREN done edge and the CE start is exactly 5 cycles. `erase_done` rises 101 cycles after the CE done edge. `busy` is high throughout. `erase_err` never pulses.
- Reset-high done: `spi_done` is held 1 out of reset → no accepted done before the first real edge. The sequence still waits for the model's edge.
- Timeout: the engine model never answers the CE byte → `erase_err` pulses at cycle 32 of CE_WT. `erase_done` never pulses. The FSM is in IDLE the next cycle, and a new request restarts the sequence with 06h.
- Request while busy: `erase_req` pulses during GAP and again during ERASE_WT → ignored. Only one pair of `spi_start` pulses occurs and only one `erase_done`.
- Mid-sequence reset: `rst`=1 for 1 cycle during CE_WT → all outputs at reset values the next cycle and the FSM in IDLE. A later request completes normally.
- Done/timeout collision: the model's done edge lands exactly at timeout cycle 32 → the done is accepted, there is no `erase_err`, and the flow continues to ERASE_WT.
